// File: rtl/dbg_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_bridge_pkg
// Description : Shared types and constants for the serial debug bus bridge:
//               FSM state encoding, response codes and default opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_e;

  // Single-byte responses
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Default frame opcodes ('W' and 'R')
  localparam logic [7:0] DEF_CMD_WRITE = 8'h57;
  localparam logic [7:0] DEF_CMD_READ  = 8'h52;

endpackage
`default_nettype wire

// File: rtl/dbg_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dbg_bus_bridge
// Description : Serial-command bus initiator. Parses W/R frames from a UART
//               byte stream, performs one word access on the SoC bus and
//               returns ACK, read data or NAK as a response byte stream.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_bus_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ       = DEF_CMD_READ
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_we,
  input  logic [31:0] bus_rdata,
  output logic        busy,
  output logic        rx_drop
);

  // Timeout counter width; kept at least one bit for tiny timeouts
  localparam int unsigned   TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;       // byte index inside ADDR/DATA field
  logic            is_wr_q, is_wr_d;   // frame is a write
  logic [31:0]     addr_q, addr_d;     // word address, bits [1:0] held at 0
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     resp_q, resp_d;     // response shift register, LSB first
  logic [2:0]      rcnt_q, rcnt_d;     // response bytes still to send
  logic [TW-1:0]   tmo_q, tmo_d;       // inter-byte idle counter

  // Next-state and datapath updates for the frame parser / bus FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    rcnt_d  = rcnt_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_wr_d = (rx_data == CMD_WRITE);
            cnt_d   = 2'd0;
            tmo_d   = '0;
            state_d = ADDR;
          end else begin
            resp_d  = {24'h0, NAK};
            rcnt_d  = 3'd1;
            state_d = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_valid) begin
          // An arriving byte wins over a simultaneous timeout expiry
          addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          addr_d[1:0] = 2'b00;
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = is_wr_q ? DATA : BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_q == TMO_MAX) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DATA: begin
        if (rx_valid) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
          tmo_d = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = 2'd0;
            state_d = BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_q == TMO_MAX) begin
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      BUS: begin
        // No timeout here: a withheld grant stalls the bridge indefinitely
        if (bus_gnt) begin
          if (is_wr_q) begin
            resp_d = {24'h0, ACK};
            rcnt_d = 3'd1;
          end else begin
            resp_d = bus_rdata;
            rcnt_d = 3'd4;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        if (tx_ready) begin
          resp_d = {8'h00, resp_q[31:8]};
          rcnt_d = rcnt_q - 3'd1;
          if (rcnt_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      is_wr_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      resp_q  <= 32'h0;
      rcnt_q  <= 3'd0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      rcnt_q  <= rcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once
  assign bus_req   = (state_q == BUS);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = (bus_req && is_wr_q) ? 4'hf : 4'h0;
  assign tx_valid  = (state_q == RESP);
  assign tx_data   = tx_valid ? resp_q[7:0] : 8'h00;
  assign busy      = (state_q != IDLE);
  assign rx_drop   = rx_valid && (state_q == BUS || state_q == RESP);

endmodule
`default_nettype wire

// File: tb/tb_dbg_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dbg_bus_bridge
// Description : Scoreboard bench for dbg_bus_bridge. Stimulus pushes the
//               expected bus accesses and response bytes; a monitor pops and
//               compares them whenever the bridge presents a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_bus_bridge;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    bit          is_wr;
  } bus_txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_we;
  logic [31:0] bus_rdata = 32'h0;
  logic        busy;
  logic        rx_drop;

  // Handshake control written by the stimulus, applied by the driver
  bit hs_random  = 1'b0;
  bit gnt_force  = 1'b1;
  bit rdy_force  = 1'b1;
  bit forbid_req = 1'b0;

  int total = 0;
  int bad   = 0;

  bus_txn_t    exp_bus[$];
  logic [7:0]  exp_tx[$];
  bus_txn_t    mon_t;
  logic [7:0]  mon_b;

  dbg_bus_bridge #(
    .TIMEOUT_CYCLES (TMO),
    .CMD_WRITE      (8'h57),
    .CMD_READ       (8'h52)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .rx_drop   (rx_drop)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: what one frame must produce on the bus and the tx side
  task automatic model_frame(input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd);
    bus_txn_t t;
    if (op == 8'h57) begin
      t.addr = a & 32'hFFFF_FFFC; t.wdata = d; t.we = 4'hf; t.is_wr = 1'b1;
      exp_bus.push_back(t);
      exp_tx.push_back(8'h06);
    end else if (op == 8'h52) begin
      t.addr = a & 32'hFFFF_FFFC; t.wdata = 32'h0; t.we = 4'h0; t.is_wr = 1'b0;
      exp_bus.push_back(t);
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rd >> (8 * i)));
    end else begin
      exp_tx.push_back(8'h15);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int gap_max);
    int n;
    n = (op == 8'h57) ? 8 : (op == 8'h52) ? 4 : 0;
    send_byte(op);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_byte((i < 4) ? 8'(a >> (8 * i)) : 8'(d >> (8 * (i - 4))));
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) done = 1'b1;
    end
    check("drain", {31'h0, done}, 32'h1);
    if (!done) begin
      exp_tx.delete();
      exp_bus.delete();
    end
    @(posedge clk); #1;
  endtask

  // Handshake driver: applies forced or random grant/ready each cycle
  initial forever begin
    @(posedge clk); #2;
    if (hs_random) begin
      bus_gnt  = ($urandom_range(0, 2) == 0);
      tx_ready = ($urandom_range(0, 1) == 1);
    end else begin
      bus_gnt  = gnt_force;
      tx_ready = rdy_force;
    end
  end

  // Monitor: pops expectations whenever a bus or tx transfer happens
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (bus_req && bus_gnt) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", bus_addr, 32'hxxxx_xxxx);
        end else begin
          mon_t = exp_bus.pop_front();
          check("bus_addr", bus_addr, mon_t.addr);
          if (mon_t.is_wr) check("bus_wdata", bus_wdata, mon_t.wdata);
          check("bus_we", {28'h0, bus_we}, {28'h0, mon_t.we});
        end
      end
      if (forbid_req && bus_req) check("bus_req_forbidden", 32'h1, 32'h0);
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          check("tx_unexpected", {24'h0, tx_data}, 32'hxxxx_xxxx);
        end else begin
          mon_b = exp_tx.pop_front();
          check("tx_data", {24'h0, tx_data}, {24'h0, mon_b});
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] a, d, rd, d0;
    bit          ok;
    int          kind;

    // ---------------- reset values ----------------
    repeat (3) @(posedge clk); #1;
    check("rst_bus_req",   {31'h0, bus_req}, 32'h0);
    check("rst_bus_addr",  bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_we",    {28'h0, bus_we}, 32'h0);
    check("rst_tx_valid",  {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data",   {24'h0, tx_data}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    check("rst_rx_drop",   {31'h0, rx_drop}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ---------------- directed write, grant tied high ----------------
    gnt_force = 1'b1; rdy_force = 1'b1;
    model_frame(8'h57, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0);
    send_frame(8'h57, 32'h0000_8000, 32'hDEAD_BEEF, 0);
    check("req_latency", {31'h0, bus_req}, 32'h1);
    @(posedge clk); #1;
    check("gnt_to_tx", {31'h0, tx_valid}, 32'h1);
    wait_idle();

    // ---------------- directed read ----------------
    bus_rdata = 32'h1234_5678;
    model_frame(8'h52, 32'h0002_0020, 32'h0, bus_rdata);
    send_frame(8'h52, 32'h0002_0020, 32'h0, 0);
    wait_idle();

    // ---------------- bad opcode -> NAK, never touches the bus ----------------
    forbid_req = 1'b1;
    model_frame(8'hAA, 32'h0, 32'h0, 32'h0);
    send_byte(8'hAA);
    wait_idle();
    check("nak_busy_clear", {31'h0, busy}, 32'h0);

    // ---------------- timeout after 3 address bytes ----------------
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    repeat (TMO) begin @(posedge clk); #1; end
    check("timeout_idle", {31'h0, busy}, 32'h0);
    forbid_req = 1'b0;
    bus_rdata = 32'hCAFE_F00D;
    model_frame(8'h52, 32'h0000_1234, 32'h0, bus_rdata);
    send_frame(8'h52, 32'h0000_1234, 32'h0, 0);
    wait_idle();

    // ---------------- longest allowed gap (same-edge byte wins) ----------------
    bus_rdata = 32'hA5A5_0F0F;
    model_frame(8'h52, 32'h4000_0007, 32'h0, bus_rdata);
    send_byte(8'h52); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    check("gap_busy", {31'h0, busy}, 32'h1);
    send_byte(8'h40);
    wait_idle();

    // ---------------- stalled grant and slow transmitter ----------------
    gnt_force = 1'b0; rdy_force = 1'b0;
    bus_rdata = 32'h89AB_CDEF;
    model_frame(8'h52, 32'h0000_0100, 32'h0, bus_rdata);
    send_frame(8'h52, 32'h0000_0100, 32'h0, 0);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin rx_valid = 1'b1; rx_data = 8'h57; end
      @(negedge clk);
      if (bus_req !== 1'b1) ok = 1'b0;
      if (i == 3) check("rx_drop_in_bus", {31'h0, rx_drop}, 32'h1);
      @(posedge clk); #1;
      if (i == 3) rx_valid = 1'b0;
    end
    check("req_hold", {31'h0, ok}, 32'h1);
    gnt_force = 1'b1;
    @(posedge clk); #1;
    gnt_force = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ok = 1'b1;
      @(negedge clk);
      d0 = {24'h0, tx_data};
      if (tx_valid !== 1'b1) ok = 1'b0;
      for (int k = 1; k < 5; k++) begin
        @(negedge clk);
        if (tx_valid !== 1'b1 || {24'h0, tx_data} !== d0) ok = 1'b0;
      end
      check("tx_stable", {31'h0, ok}, 32'h1);
      @(posedge clk); #1;
      rdy_force = 1'b1;
      @(posedge clk); #1;
      rdy_force = 1'b0;
    end
    rdy_force = 1'b1;
    wait_idle();

    // ---------------- reset while waiting in BUS ----------------
    gnt_force = 1'b0;
    send_frame(8'h57, 32'h0000_0040, 32'h1111_2222, 0);
    check("pre_reset_req", {31'h0, bus_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("async_req_drop", {31'h0, bus_req}, 32'h0);
    check("async_tx_valid", {31'h0, tx_valid}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    gnt_force = 1'b1;
    model_frame(8'h57, 32'h0000_0044, 32'h3333_4444, 32'h0);
    send_frame(8'h57, 32'h0000_0044, 32'h3333_4444, 0);
    wait_idle();

    // ---------------- randomized frames ----------------
    hs_random = 1'b1;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 4);
      a  = $urandom;
      d  = $urandom;
      rd = $urandom;
      if (kind < 2)      op = 8'h57;
      else if (kind < 4) op = 8'h52;
      else begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'hAA;
      end
      bus_rdata = rd;
      model_frame(op, a, d, rd);
      send_frame(op, a, d, 3);
      wait_idle();
    end
    hs_random = 1'b0;

    check("exp_bus_left", exp_bus.size(), 32'h0);
    check("exp_tx_left",  exp_tx.size(),  32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
